// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with flush; bubbles carry all-zero control.
// Optional macro PIPE_STAGE_SKID_EN adds a skid entry and a registered in_ready.
module pipe_stage_elastic #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 105,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    // state | meaning
    // EMPTY | nothing held, out_valid low
    // ONE   | main register holds the head entry
    // TWO   | main holds the head, skid holds the next entry (skid build only)
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              accept;
    logic              deliver;

    assign out_valid = (state != S_EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = CNT_W'(state);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_ready_q;

    // in_ready is a flop so backpressure never ripples combinationally upstream
    assign in_ready = in_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_EMPTY;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && deliver) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (accept) begin
                        skid_ctrl  <= in_ctrl;
                        skid_data  <= in_data;
                        state      <= S_TWO;
                        in_ready_q <= 1'b0;
                    end else if (deliver) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (deliver) begin
                        main_ctrl  <= skid_ctrl;
                        main_data  <= skid_data;
                        state      <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    // Without a skid slot, a new entry can only land when the head leaves this cycle.
    assign in_ready = !out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (deliver) begin
                        state <= S_EMPTY;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end
`endif

endmodule
